// File: rtl/noc_pkg.sv
// Shared router constants, port indices, the arbiter state encoding and a one-hot helper.
package noc_pkg;

  localparam int unsigned NPORT  = 5;
  localparam int unsigned DW     = 3;
  localparam int unsigned FLIT_W = 4;

  localparam logic [DW-1:0] LOCAL = 3'd0;
  localparam logic [DW-1:0] NORTH = 3'd1;
  localparam logic [DW-1:0] EAST  = 3'd2;
  localparam logic [DW-1:0] SOUTH = 3'd3;
  localparam logic [DW-1:0] WEST  = 3'd4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Indices >= NPORT map to all-zero.
  function automatic logic [NPORT-1:0] idx_to_onehot(input logic [DW-1:0] idx);
    logic [NPORT-1:0] oh;
    oh = '0;
    for (int unsigned j = 0; j < NPORT; j++) begin
      if (idx == DW'(j)) oh[j] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter.sv
// Per-output round-robin arbiter that locks to the winning input for a whole packet
// and releases on the transferred tail flit.
module rr_lock_arbiter
  import noc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] cand_i,
  input  logic [NPORT-1:0] req_i,
  input  logic [NPORT-1:0] tail_i,
  input  logic             rdy_i,
  output logic [NPORT-1:0] sel_o,
  output logic [NPORT-1:0] gnt_c_o
);

  localparam int unsigned SW = DW + 1;

  arb_state_e       state_q;
  logic [DW-1:0]    ptr_q, owner_q;
  logic [NPORT-1:0] sel_q;
  logic [DW-1:0]    pick_d, ptr_d;
  logic [SW-1:0]    scan_idx;
  logic             found_d;
  logic             xfer_c;

  // First candidate at or after the pointer, wrapping modulo NPORT.
  always_comb begin
    found_d  = 1'b0;
    pick_d   = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      scan_idx = SW'(ptr_q) + SW'(i);
      if (scan_idx >= SW'(NPORT)) scan_idx = scan_idx - SW'(NPORT);
      if (!found_d && cand_i[scan_idx[DW-1:0]]) begin
        found_d = 1'b1;
        pick_d  = scan_idx[DW-1:0];
      end
    end
    ptr_d = (pick_d == DW'(NPORT - 1)) ? '0 : pick_d + DW'(1);
  end

  assign xfer_c  = (state_q == LOCKED) && req_i[owner_q] && rdy_i;
  assign gnt_c_o = xfer_c ? sel_q : '0;
  assign sel_o   = sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      sel_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            owner_q <= pick_d;
            ptr_q   <= ptr_d;
            sel_q   <= idx_to_onehot(pick_d);
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer_c && tail_i[owner_q]) begin
            sel_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          sel_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator: builds per-output candidate vectors, runs one locking arbiter per
// output, merges grants and tracks sticky invalid-destination errors.
module switch_allocator
  import noc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic [DW-1:0]    dest0,
  input  logic [DW-1:0]    dest1,
  input  logic [DW-1:0]    dest2,
  input  logic [DW-1:0]    dest3,
  input  logic [DW-1:0]    dest4,
  input  logic [NPORT-1:0] tail,
  input  logic [NPORT-1:0] out_rdy,
  output logic [NPORT-1:0] sel0,
  output logic [NPORT-1:0] sel1,
  output logic [NPORT-1:0] sel2,
  output logic [NPORT-1:0] sel3,
  output logic [NPORT-1:0] sel4,
  output logic [NPORT-1:0] gnt,
  output logic [NPORT-1:0] err_dest
);

  logic [DW-1:0]    dest    [NPORT];
  logic [NPORT-1:0] cand    [NPORT];
  logic [NPORT-1:0] arb_sel [NPORT];
  logic [NPORT-1:0] arb_gnt [NPORT];
  logic [NPORT-1:0] bad_c;
  logic [NPORT-1:0] err_q, err_d;

  assign dest[0] = dest0;
  assign dest[1] = dest1;
  assign dest[2] = dest2;
  assign dest[3] = dest3;
  assign dest[4] = dest4;

  // Out-of-range destinations never become candidates on any output.
  always_comb begin
    bad_c = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      cand[k] = '0;
      for (int unsigned j = 0; j < NPORT; j++) begin
        cand[k][j] = req[j] && (dest[j] == DW'(k));
      end
    end
    for (int unsigned j = 0; j < NPORT; j++) begin
      bad_c[j] = req[j] && (dest[j] >= DW'(NPORT));
    end
    err_d = err_q | bad_c;
  end

  for (genvar k = 0; k < NPORT; k++) begin : g_arb
    rr_lock_arbiter u_arb (
      .clk     (clk),
      .rst     (rst),
      .cand_i  (cand[k]),
      .req_i   (req),
      .tail_i  (tail),
      .rdy_i   (out_rdy[k]),
      .sel_o   (arb_sel[k]),
      .gnt_c_o (arb_gnt[k])
    );
  end

  always_comb begin
    gnt = '0;
    for (int unsigned k = 0; k < NPORT; k++) gnt = gnt | arb_gnt[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_dest = err_q;
  assign sel0     = arb_sel[0];
  assign sel1     = arb_sel[1];
  assign sel2     = arb_sel[2];
  assign sel3     = arb_sel[3];
  assign sel4     = arb_sel[4];

endmodule

// File: tb/tb_switch_allocator.sv
// Directed table-driven bench for switch_allocator plus a hand-written async reset sequence.
module tb_switch_allocator;
  import noc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req, tail, out_rdy;
  logic [2:0] dest0, dest1, dest2, dest3, dest4;
  logic [4:0] sel0, sel1, sel2, sel3, sel4, gnt, err_dest;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .dest0    (dest0),
    .dest1    (dest1),
    .dest2    (dest2),
    .dest3    (dest3),
    .dest4    (dest4),
    .tail     (tail),
    .out_rdy  (out_rdy),
    .sel0     (sel0),
    .sel1     (sel1),
    .sel2     (sel2),
    .sel3     (sel3),
    .sel4     (sel4),
    .gnt      (gnt),
    .err_dest (err_dest)
  );

  typedef struct {
    logic [4:0]  req;
    logic [4:0]  tail;
    logic [4:0]  rdy;
    logic [14:0] dest;
    logic [24:0] esel;
    logic [4:0]  egnt;
    logic [4:0]  eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] dst(int j, logic [2:0] d);
    return 15'(d) << (3 * j);
  endfunction

  function automatic logic [24:0] sk(int k, logic [4:0] v);
    return 25'(v) << (5 * k);
  endfunction

  task automatic add(input logic [4:0] rq, input logic [4:0] tl, input logic [4:0] rd,
                     input logic [14:0] ds, input logic [24:0] es, input logic [4:0] eg,
                     input logic [4:0] ee);
    vec_t v;
    v.req = rq; v.tail = tl; v.rdy = rd; v.dest = ds;
    v.esel = es; v.egnt = eg; v.eerr = ee;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int id, input logic [24:0] act, input logic [24:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row=%0d actual=%h expected=%h", nm, id, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rq, input logic [4:0] tl, input logic [4:0] rd,
                       input logic [14:0] ds);
    req = rq; tail = tl; out_rdy = rd;
    {dest4, dest3, dest2, dest1, dest0} = ds;
  endtask

  task automatic check_all(input int id, input logic [24:0] es, input logic [4:0] eg,
                           input logic [4:0] ee);
    chk("sel", id, {sel4, sel3, sel2, sel1, sel0}, es);
    chk("gnt", id, 25'(gnt), 25'(eg));
    chk("err_dest", id, 25'(err_dest), 25'(ee));
  endtask

  logic [14:0] d_a, d_b, d_c, d_d, d_e;
  logic [24:0] s_c;

  initial begin
    d_a = dst(1, SOUTH);
    d_b = dst(0, EAST) | dst(2, EAST) | dst(4, EAST);
    d_c = dst(2, LOCAL);
    d_d = dst(0, WEST) | dst(4, LOCAL);
    d_e = dst(3, 3'd6);
    s_c = sk(0, 5'b00100);

    // Single 3-flit packet, input 1 -> output 3
    add(5'b00010, 5'b00000, 5'h1F, d_a, '0, 5'b00000, 5'b0);
    add(5'b00010, 5'b00000, 5'h1F, d_a, sk(3, 5'b00010), 5'b00010, 5'b0);
    add(5'b00010, 5'b00000, 5'h1F, d_a, sk(3, 5'b00010), 5'b00010, 5'b0);
    add(5'b00010, 5'b00010, 5'h1F, d_a, sk(3, 5'b00010), 5'b00010, 5'b0);
    add(5'b00000, 5'b00000, 5'h1F, '0,  '0, 5'b00000, 5'b0);
    // Contention on output 2 from inputs 0, 2, 4 with single-flit packets
    add(5'b10101, 5'b10101, 5'h1F, d_b, '0, 5'b00000, 5'b0);
    add(5'b10101, 5'b10101, 5'h1F, d_b, sk(2, 5'b00001), 5'b00001, 5'b0);
    add(5'b10101, 5'b10101, 5'h1F, d_b, '0, 5'b00000, 5'b0);
    add(5'b10101, 5'b10101, 5'h1F, d_b, sk(2, 5'b00100), 5'b00100, 5'b0);
    add(5'b10101, 5'b10101, 5'h1F, d_b, '0, 5'b00000, 5'b0);
    add(5'b10101, 5'b10101, 5'h1F, d_b, sk(2, 5'b10000), 5'b10000, 5'b0);
    add(5'b10101, 5'b10101, 5'h1F, d_b, '0, 5'b00000, 5'b0);
    add(5'b10101, 5'b10101, 5'h1F, d_b, sk(2, 5'b00001), 5'b00001, 5'b0);
    add(5'b00000, 5'b00000, 5'h1F, '0,  '0, 5'b00000, 5'b0);
    // 4-flit packet 2 -> 0 with backpressure, an empty-buffer gap and a stalled tail
    add(5'b00100, 5'b00000, 5'h1F, d_c, '0,  5'b00000, 5'b0);
    add(5'b00100, 5'b00000, 5'h1F, d_c, s_c, 5'b00100, 5'b0);
    add(5'b00100, 5'b00000, 5'h1E, d_c, s_c, 5'b00000, 5'b0);
    add(5'b00100, 5'b00000, 5'h1E, d_c, s_c, 5'b00000, 5'b0);
    add(5'b00100, 5'b00000, 5'h1F, d_c, s_c, 5'b00100, 5'b0);
    add(5'b00100, 5'b00000, 5'h1F, d_c, s_c, 5'b00100, 5'b0);
    add(5'b00000, 5'b00000, 5'h1F, d_c, s_c, 5'b00000, 5'b0);
    add(5'b00100, 5'b00100, 5'h1E, d_c, s_c, 5'b00000, 5'b0);
    add(5'b00100, 5'b00100, 5'h1F, d_c, s_c, 5'b00100, 5'b0);
    add(5'b00000, 5'b00000, 5'h1F, '0,  '0,  5'b00000, 5'b0);
    // Parallel: input 0 -> output 4 and input 4 -> output 0 in the same cycle
    add(5'b10001, 5'b10001, 5'h1F, d_d, '0, 5'b00000, 5'b0);
    add(5'b10001, 5'b10001, 5'h1F, d_d, sk(4, 5'b00001) | sk(0, 5'b10000), 5'b10001, 5'b0);
    add(5'b00000, 5'b00000, 5'h1F, '0,  '0, 5'b00000, 5'b0);
    // Invalid destination on input 3, sticky error
    add(5'b01000, 5'b00000, 5'h1F, d_e, '0, 5'b00000, 5'b00000);
    add(5'b01000, 5'b00000, 5'h1F, d_e, '0, 5'b00000, 5'b01000);
    add(5'b00000, 5'b00000, 5'h1F, '0,  '0, 5'b00000, 5'b01000);

    rst = 1'b1;
    drive('0, '0, 5'h1F, '0);
    #2;
    check_all(-1, '0, 5'b0, 5'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].tail, vecs[i].rdy, vecs[i].dest);
      #4;
      check_all(i, vecs[i].esel, vecs[i].egnt, vecs[i].eerr);
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a packet, then re-arbitration
    drive(5'b00010, 5'b00000, 5'h1F, d_a);
    #4;
    check_all(100, '0, 5'b00000, 5'b01000);
    @(posedge clk); #3;
    check_all(101, sk(3, 5'b00010), 5'b00010, 5'b01000);
    rst = 1'b1;
    #1;
    check_all(102, '0, 5'b00000, 5'b00000);
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    check_all(103, '0, 5'b00000, 5'b00000);
    @(posedge clk); #3;
    check_all(104, sk(3, 5'b00010), 5'b00010, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Control-side counterpart of the router crossbar. It consumes per-input-port routing requests and produces the five one-hot crossbar selects (sel0..sel4).
- Each output port has a round-robin arbiter that locks to the winning input for a whole packet (wormhole) and releases it on the tail flit.
- It also returns per-input grant/pop strobes to the input buffers.
- Sits between the input buffers plus route computation and the registered 5x5 crossbar, 4-bit flits.

Parameters:
- NPORT, 5, number of router ports. Only 5 is supported; it fixes the select width.
- DW, 3, width of each encoded destination-port field.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  5  req[j]=1: input j holds a valid flit at its buffer head.
- dest0..dest4  input  3 each  encoded output port (0..4) requested by input j; sampled only while req[j]=1.
- tail  input  5  tail[j]=1: head flit of input j is the last flit of its packet. A single-flit packet has head and tail on the same flit.
- out_rdy  input  5  out_rdy[k]=1: downstream of output k can accept a flit this cycle.
- sel0..sel4  output  5 each  crossbar select for output k. Bit j set means output k takes input j. One-hot or all-zero.
- gnt  output  5  gnt[j]=1: flit of input j crosses the crossbar this cycle; the input buffer pops.
- err_dest  output  5  sticky: input j presented a dest value >= 5.

Behaviour:
- Reset (async, any time, including mid-packet):
  - sel0..sel4 = 0, gnt = 0, err_dest = 0.
  - All output states = IDLE, all round-robin pointers = 0, all owners = 0.
  - Packets in flight lose their lock; the input buffers are flushed separately.
- Per output k, 2-state FSM:
  - IDLE: candidates = {j : req[j] && dest_j==k}. If there is no candidate, stay IDLE.
  - Else pick the first candidate scanning j = ptr[k], ptr[k]+1, ... mod 5. At the edge: owner[k] <= j, ptr[k] <= (j+1) mod 5, state <= LOCKED.
  - LOCKED: sel_k = one-hot(owner[k]) (registered; changes only at the IDLE<->LOCKED edges).
  - A transfer occurs in a cycle when req[owner] && out_rdy[k]. A transfer with tail[owner]=1 moves state to IDLE at the next edge. Otherwise stay LOCKED.
- IDLE output: sel_k = 5'b00000. A flit never crosses while IDLE.
- gnt[j] is combinational from registered state: gnt[j] = OR over k of (LOCKED_k && owner[k]==j && req[j] && out_rdy[k]).
  - At most one gnt per input, since an input is owned by at most one output; that is guaranteed because an input's dest is constant across its packet.
- Latency:
  - Head flit req at cycle N in IDLE -> sel_k valid and first gnt possible at N+1.
  - The crossbar registers the data, so the flit appears on o_k at N+2.
- Packet boundary: one mandatory IDLE bubble cycle after each tail. Back-to-back packets on one output take length+1 cycles each.
- Backpressure: out_rdy[k]=0 while LOCKED -> gnt low, sel_k and owner held, no release even if tail is presented.
- Owner drops req mid-packet (empty buffer): lock held, gnt low, resume when req returns.
- Invalid dest (5,6,7) with req[j]=1: never a candidate for any output; err_dest[j] <= 1 at the edge, cleared only by rst.
- Simultaneous arbitration on different outputs is independent; up to 5 grants in one cycle.
- Pointer advances only on grant, never in idle cycles.

Decomposition:
- Shared package noc_pkg:
  - NPORT=5, DW=3, FLIT_W=4.
  - Port index constants LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
  - Function idx_to_onehot (3-bit -> 5-bit).
  - FSM state encoding IDLE=1'b0, LOCKED=1'b1.
- Sub-module rr_lock_arbiter:
  - One instance per output.
  - Inputs: 5-bit candidate vector, tail/ready qualifiers.
  - Holds ptr/owner/state and emits one-hot sel and per-input grant vector.
  - The top ORs the five grant vectors into gnt and generates candidate vectors and err_dest.

Test Plan:
- Reset: assert rst mid-packet with sel3=5'b00010 -> sel0..4=0, gnt=0, err_dest=0 immediately (asynchronous); after release, req[1] dest1=3 is re-granted in 1 cycle.
- Single 3-flit packet: req[1]=1, dest1=3, out_rdy=5'b11111, tail on 3rd flit -> sel3=5'b00010 from N+1, gnt=5'b00010 for N+1..N+3, sel3=0 at N+4.
- Contention: inputs 0,2,4 all dest 2, continuous single-flit packets, ptr=0 -> owners 0,2,4,0 in order, each grant followed by one idle cycle.
- Backpressure: 4-flit packet 2->0, out_rdy[0]=0 on 2nd and 3rd cycles -> gnt[2] low those cycles, sel0=5'b00100 held throughout, tail completes two cycles late.
- Parallel: in0->out4 and in4->out0 requested the same cycle -> sel4=5'b00001 and sel0=5'b10000 at N+1, gnt=5'b10001.
- Invalid dest: req[3]=1, dest3=6 -> err_dest=5'b01000 next cycle, gnt[3] never asserted, all sel unchanged.
